// File: rtl/flow_pkg.sv
// Shared constants and types for the optical-flow gradient path.
// Optional build macro: FLOW_GRAD_ROUND_EN (round half up before the final >>> 2).
package flow_pkg;

   localparam int IMG_W      = 64;
   localparam int IMG_H      = 64;
   localparam int DATA_WIDTH = 8;
   localparam int GRAD_WIDTH = DATA_WIDTH + 1;
   localparam int SUM_WIDTH  = DATA_WIDTH + 3;
   localparam int X_WIDTH    = $clog2(IMG_W);
   localparam int Y_WIDTH    = $clog2(IMG_H);

   localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(IMG_W - 1);
   localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(IMG_H - 1);

   typedef logic signed [SUM_WIDTH-1:0]  sum_t;
   typedef logic signed [GRAD_WIDTH-1:0] grad_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] prev;
      logic [DATA_WIDTH-1:0] curr;
   } pix_pair_t;

   function automatic sum_t zext(input logic [DATA_WIDTH-1:0] v);
      return {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, v};
   endfunction

   // Divide a 4-term sum by four; the result always fits GRAD_WIDTH.
   function automatic grad_t grad_shift(input sum_t s);
      sum_t t;
`ifdef FLOW_GRAD_ROUND_EN
      t = s + sum_t'(2);
`else
      t = s;
`endif
      t = t >>> 2;
      return t[GRAD_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/flow_gradient_calc_if.sv
// Pixel-pair input stream and gradient output stream of the gradient stage.
interface flow_gradient_calc_if import flow_pkg::*; ();

   logic [DATA_WIDTH-1:0] prev_pixel;
   logic [DATA_WIDTH-1:0] curr_pixel;
   logic                  in_valid;
   logic                  in_sof;
   grad_t                 ix;
   grad_t                 iy;
   grad_t                 it;
   logic                  out_valid;
   logic                  out_sof;
   logic                  out_eof;

   modport master (
      output prev_pixel, curr_pixel, in_valid, in_sof,
      input  ix, iy, it, out_valid, out_sof, out_eof
   );

   modport slave (
      input  prev_pixel, curr_pixel, in_valid, in_sof,
      output ix, iy, it, out_valid, out_sof, out_eof
   );

endinterface

// File: rtl/flow_line_buffer.sv
// One-row buffer of (prev,curr) pixel pairs; registered read, read-before-write.
module flow_line_buffer import flow_pkg::*; #(
   parameter int DEPTH = IMG_W,
   parameter int WIDTH = 2 * DATA_WIDTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] rd_data_d;

   // Read data holds between reads so the window stays stable across idle cycles.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      rd_data_q <= rd_data_d;
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/flow_gradient_calc.sv
// Three-stage 2x2x2 spatio-temporal gradient pipeline (window, sums, shift).
// Optional build macro: FLOW_GRAD_ROUND_EN (handled in flow_pkg::grad_shift).
module flow_gradient_calc import flow_pkg::*; (
   input logic                 clk,
   input logic                 reset,
   flow_gradient_calc_if.slave bus
);

   logic [X_WIDTH-1:0] x_q, x_d, pos_x;
   logic [Y_WIDTH-1:0] y_q, y_d, pos_y;
   pix_pair_t          in_pair, lb_rdata;
   pix_pair_t          a_q, a_d, c_q, c_d, d_q, d_d;
   logic               s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
   logic               s1_eof_q, s1_eof_d, s1_border_q, s1_border_d;
   sum_t               sx_q, sx_d, sy_q, sy_d, st_q, st_d;
   logic               s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d;
   logic               s2_eof_q, s2_eof_d, s2_border_q, s2_border_d;
   grad_t              ix_q, ix_d, iy_q, iy_d, it_q, it_d;
   logic               out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;

   assign in_pair = '{prev: bus.prev_pixel, curr: bus.curr_pixel};
   assign pos_x   = bus.in_sof ? '0 : x_q;
   assign pos_y   = bus.in_sof ? '0 : y_q;

   flow_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (2 * DATA_WIDTH)
   ) u_line_buffer (
      .clk     (clk),
      .rd_en   (bus.in_valid),
      .rd_addr (pos_x),
      .rd_data (lb_rdata),
      .wr_en   (bus.in_valid),
      .wr_addr (pos_x),
      .wr_data (in_pair)
   );

   // Position counters and window capture; the old line-buffer word becomes the new 'a'.
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      a_d         = a_q;
      c_d         = c_q;
      d_d         = d_q;
      s1_valid_d  = bus.in_valid;
      s1_sof_d    = s1_sof_q;
      s1_eof_d    = s1_eof_q;
      s1_border_d = s1_border_q;
      if (bus.in_valid) begin
         x_d = (pos_x == X_MAX) ? '0 : pos_x + X_WIDTH'(1);
         if (pos_x == X_MAX) y_d = (pos_y == Y_MAX) ? '0 : pos_y + Y_WIDTH'(1);
         else                y_d = pos_y;
         a_d         = lb_rdata;
         c_d         = d_q;
         d_d         = in_pair;
         s1_sof_d    = (pos_x == '0) && (pos_y == '0);
         s1_eof_d    = (pos_x == X_MAX) && (pos_y == Y_MAX);
         s1_border_d = (pos_x == '0) || (pos_y == '0);
      end
   end

   always_comb begin
      sx_d        = sx_q;
      sy_d        = sy_q;
      st_d        = st_q;
      s2_valid_d  = s1_valid_q;
      s2_sof_d    = s2_sof_q;
      s2_eof_d    = s2_eof_q;
      s2_border_d = s2_border_q;
      if (s1_valid_q) begin
         sx_d = (zext(lb_rdata.curr) - zext(a_q.curr)) + (zext(d_q.curr) - zext(c_q.curr))
              + (zext(lb_rdata.prev) - zext(a_q.prev)) + (zext(d_q.prev) - zext(c_q.prev));
         sy_d = (zext(c_q.curr) - zext(a_q.curr)) + (zext(d_q.curr) - zext(lb_rdata.curr))
              + (zext(c_q.prev) - zext(a_q.prev)) + (zext(d_q.prev) - zext(lb_rdata.prev));
         st_d = (zext(a_q.curr) + zext(lb_rdata.curr) + zext(c_q.curr) + zext(d_q.curr))
              - (zext(a_q.prev) + zext(lb_rdata.prev) + zext(c_q.prev) + zext(d_q.prev));
         s2_sof_d    = s1_sof_q;
         s2_eof_d    = s1_eof_q;
         s2_border_d = s1_border_q;
      end
   end

   // Border samples (row 0 / column 0) are forced to zero so stale buffer data never leaks.
   always_comb begin
      ix_d        = ix_q;
      iy_d        = iy_q;
      it_d        = it_q;
      out_valid_d = s2_valid_q;
      out_sof_d   = s2_valid_q & s2_sof_q;
      out_eof_d   = s2_valid_q & s2_eof_q;
      if (s2_valid_q) begin
         ix_d = s2_border_q ? '0 : grad_shift(sx_q);
         iy_d = s2_border_q ? '0 : grad_shift(sy_q);
         it_d = s2_border_q ? '0 : grad_shift(st_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q         <= '0;
         y_q         <= '0;
         a_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         s1_border_q <= 1'b0;
         sx_q        <= '0;
         sy_q        <= '0;
         st_q        <= '0;
         s2_valid_q  <= 1'b0;
         s2_sof_q    <= 1'b0;
         s2_eof_q    <= 1'b0;
         s2_border_q <= 1'b0;
         ix_q        <= '0;
         iy_q        <= '0;
         it_q        <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         a_q         <= a_d;
         c_q         <= c_d;
         d_q         <= d_d;
         s1_valid_q  <= s1_valid_d;
         s1_sof_q    <= s1_sof_d;
         s1_eof_q    <= s1_eof_d;
         s1_border_q <= s1_border_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         st_q        <= st_d;
         s2_valid_q  <= s2_valid_d;
         s2_sof_q    <= s2_sof_d;
         s2_eof_q    <= s2_eof_d;
         s2_border_q <= s2_border_d;
         ix_q        <= ix_d;
         iy_q        <= iy_d;
         it_q        <= it_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
      end
   end

   assign bus.ix        = ix_q;
   assign bus.iy        = iy_q;
   assign bus.it        = it_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_eof   = out_eof_q;

endmodule

// File: tb/tb_flow_gradient_calc.sv
// Directed bench for flow_gradient_calc with a whole-frame reference model and per-cycle compare.
module tb_flow_gradient_calc;
   import flow_pkg::*;

   logic clk = 1'b0;
   logic reset;

   flow_gradient_calc_if bus ();

   flow_gradient_calc dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int x;
      int y;
      int ix;
      int iy;
      int it;
      bit sof;
      bit eof;
   } exp_t;

   exp_t expQ[$];
   int   cycle = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   curF  [IMG_H][IMG_W];
   int   prvF  [IMG_H][IMG_W];
   int   obsIx [IMG_H][IMG_W];
   int   obsIy [IMG_H][IMG_W];
   int   obsIt [IMG_H][IMG_W];
   int   mx = 0;
   int   my = 0;
   bit   checkEn = 1'b0;
   int   outCount = 0;
   int   lastSofCycle = -1;
   int   lastEofCycle = -1;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Reference: remember both frames pixel by pixel and evaluate the 2x2x2 cube directly.
   task automatic modelBeat(input int p, input int c, input bit sof);
      int x, y, sx, sy, st;
      int a, b, cc, d, pa, pb, pc, pd;
      exp_t e;
      x = sof ? 0 : mx;
      y = sof ? 0 : my;
      curF[y][x] = c;
      prvF[y][x] = p;
      e.due = cycle + 3;
      e.x   = x;
      e.y   = y;
      e.sof = (x == 0) && (y == 0);
      e.eof = (x == IMG_W - 1) && (y == IMG_H - 1);
      if (x == 0 || y == 0) begin
         e.ix = 0; e.iy = 0; e.it = 0;
      end else begin
         a  = curF[y-1][x-1]; b  = curF[y-1][x]; cc = curF[y][x-1]; d  = curF[y][x];
         pa = prvF[y-1][x-1]; pb = prvF[y-1][x]; pc = prvF[y][x-1]; pd = prvF[y][x];
         sx = (b - a) + (d - cc) + (pb - pa) + (pd - pc);
         sy = (cc - a) + (d - b) + (pc - pa) + (pd - pb);
         st = (a + b + cc + d) - (pa + pb + pc + pd);
`ifdef FLOW_GRAD_ROUND_EN
         sx += 2; sy += 2; st += 2;
`endif
         e.ix = sx >>> 2;
         e.iy = sy >>> 2;
         e.it = st >>> 2;
      end
      expQ.push_back(e);
      mx = (x + 1) % IMG_W;
      my = (x == IMG_W - 1) ? (y + 1) % IMG_H : y;
   endtask

   always @(negedge clk) begin
      bit   expV;
      exp_t e;
      if (checkEn) begin
         expV = (expQ.size() > 0) && (expQ[0].due == cycle);
         checkOutput("out_valid", int'(bus.out_valid), int'(expV));
         if (bus.out_valid === 1'b1) outCount++;
         if (bus.out_valid === 1'b1 && bus.out_sof === 1'b1) lastSofCycle = cycle;
         if (bus.out_valid === 1'b1 && bus.out_eof === 1'b1) lastEofCycle = cycle;
         if (expV) begin
            e = expQ.pop_front();
            checkOutput($sformatf("ix(%0d,%0d)", e.x, e.y), int'(bus.ix), e.ix);
            checkOutput($sformatf("iy(%0d,%0d)", e.x, e.y), int'(bus.iy), e.iy);
            checkOutput($sformatf("it(%0d,%0d)", e.x, e.y), int'(bus.it), e.it);
            checkOutput($sformatf("sof(%0d,%0d)", e.x, e.y), int'(bus.out_sof), int'(e.sof));
            checkOutput($sformatf("eof(%0d,%0d)", e.x, e.y), int'(bus.out_eof), int'(e.eof));
            obsIx[e.y][e.x] = int'(bus.ix);
            obsIy[e.y][e.x] = int'(bus.iy);
            obsIt[e.y][e.x] = int'(bus.it);
         end else begin
            checkOutput("idle_sof_eof", int'({bus.out_sof, bus.out_eof}), 0);
         end
      end
   end

   task automatic applyStimulus(input int p, input int c, input bit sof, input bit valid);
      @(posedge clk);
      #1;
      bus.prev_pixel = 8'(p);
      bus.curr_pixel = 8'(c);
      bus.in_valid   = valid;
      bus.in_sof     = sof;
      if (valid && !reset) modelBeat(p, c, sof);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b0, 1'b0);
   endtask

   // Hold reset for n edges while the input keeps toggling; in-flight samples are dropped.
   task automatic applyReset(input int n);
      @(posedge clk);
      #1;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      while (expQ.size() > 0 && expQ[expQ.size()-1].due > cycle) void'(expQ.pop_back());
      mx = 0;
      my = 0;
      for (int i = 0; i < n - 1; i++) applyStimulus(i * 37, i * 11, i[1], i[0]);
      checkOutput("rst_ix", int'(bus.ix), 0);
      checkOutput("rst_iy", int'(bus.iy), 0);
      checkOutput("rst_it", int'(bus.it), 0);
      checkOutput("rst_valid", int'(bus.out_valid), 0);
      checkOutput("rst_sof_eof", int'({bus.out_sof, bus.out_eof}), 0);
      @(posedge clk);
      #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      checkEn      = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int firstDrive, lastDrive, startCount, beats, restartDrive;
      reset          = 1'b0;
      bus.prev_pixel = '0;
      bus.curr_pixel = '0;
      bus.in_valid   = 1'b0;
      bus.in_sof     = 1'b0;

      $display("[TB] reset with toggling input");
      applyReset(5);

      $display("[TB] first beats after reset, no in_sof");
      applyStimulus(7, 9, 1'b0, 1'b1);
      firstDrive = cycle;
      applyStimulus(8, 9, 1'b0, 1'b1);
      applyStimulus(9, 9, 1'b0, 1'b1);
      idle(5);
      checkOutput("post_reset_sof_cycle", lastSofCycle, firstDrive + 3);

      $display("[TB] constant frame prev=curr=100");
      startCount = outCount;
      for (int i = 0; i < IMG_W * IMG_H; i++) begin
         applyStimulus(100, 100, i == 0, 1'b1);
         if (i == 0) firstDrive = cycle;
         lastDrive = cycle;
      end
      idle(5);
      checkOutput("const_out_count", outCount - startCount, 4096);
      checkOutput("const_sof_cycle", lastSofCycle, firstDrive + 3);
      checkOutput("const_eof_cycle", lastEofCycle, lastDrive + 3);
      checkOutput("const_ix_10_10", obsIx[10][10], 0);
      checkOutput("const_it_63_63", obsIt[63][63], 0);

      $display("[TB] horizontal ramp frame");
      for (int y = 0; y < IMG_H; y++)
         for (int x = 0; x < IMG_W; x++)
            applyStimulus(2 * x, 2 * x, (x == 0) && (y == 0), 1'b1);
      idle(5);
      checkOutput("ramp_ix_7_5", obsIx[5][7], 2);
      checkOutput("ramp_iy_7_5", obsIy[5][7], 0);
      checkOutput("ramp_it_7_5", obsIt[5][7], 0);
      checkOutput("ramp_ix_63_63", obsIx[63][63], 2);
      checkOutput("ramp_ix_row0", obsIx[0][7], 0);
      checkOutput("ramp_ix_col0", obsIx[5][0], 0);

      $display("[TB] temporal step prev=50 curr=60");
      for (int i = 0; i < 4 * IMG_W; i++) applyStimulus(50, 60, i == 0, 1'b1);
      idle(5);
      checkOutput("step_it_5_2", obsIt[2][5], 10);
      checkOutput("step_ix_5_2", obsIx[2][5], 0);
      checkOutput("step_iy_5_2", obsIy[2][5], 0);
      checkOutput("step_it_row0", obsIt[0][5], 0);
      checkOutput("step_it_col0", obsIt[2][0], 0);

      $display("[TB] alternating columns curr=255 on odd x");
      for (int i = 0; i < 4 * IMG_W; i++)
         applyStimulus(0, ((i % IMG_W) % 2 == 1) ? 255 : 0, i == 0, 1'b1);
      idle(5);
`ifdef FLOW_GRAD_ROUND_EN
      checkOutput("alt_ix_odd", obsIx[3][5], 128);
      checkOutput("alt_ix_even", obsIx[3][6], -127);
      checkOutput("alt_it_odd", obsIt[3][5], 128);
`else
      checkOutput("alt_ix_odd", obsIx[3][5], 127);
      checkOutput("alt_ix_even", obsIx[3][6], -128);
      checkOutput("alt_it_odd", obsIt[3][5], 127);
`endif
      checkOutput("alt_iy_odd", obsIy[3][5], 0);

      $display("[TB] random gaps with mid-frame restart");
      beats = 0;
      restartDrive = -1;
      while (beats < 300) begin
         if ($urandom_range(0, 3) != 0) begin
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          (beats == 0) || (beats == 100), 1'b1);
            if (beats == 100) restartDrive = cycle;
            beats++;
         end else begin
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, 1'b0);
         end
      end
      idle(5);
      checkOutput("restart_sof_cycle", lastSofCycle, restartDrive + 3);

      $display("[TB] reset with samples in flight");
      for (int i = 0; i < 20; i++) applyStimulus(i * 5, i * 7, i == 0, 1'b1);
      applyReset(3);
      for (int i = 0; i < 2 * IMG_W + 6; i++)
         applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, 1'b1);
      idle(8);
      checkOutput("queue_drained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
